// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares one SRAM-like memory port between instruction fetch and
//            data access, one outstanding transaction at a time.
//            Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking
//            (default: data has fixed priority over fetch).
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int c_strb_w = DATA_W / 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                r_owner;      // 1 = data requester owns the port
    logic                r_wr;
    logic [c_strb_w-1:0] r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic w_resp;
    logic w_grant_evt;
    logic w_grant_inst;
    logic w_grant_data;
    logic w_grant_any;

    // Response and grant share a cycle so transactions can run back-to-back
    assign w_resp       = !rst && (r_state == c_st_wait) && mem_data_ok;
    assign w_grant_evt  = !rst && ((r_state == c_st_idle) || w_resp);
    assign w_grant_any  = w_grant_inst || w_grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;  // 1 = data was granted last

    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (w_grant_evt) begin
            if (inst_req && data_req) begin
                w_grant_data = !r_last_grant;
                w_grant_inst = r_last_grant;
            end else begin
                w_grant_data = data_req;
                w_grant_inst = inst_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b0;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_data;
        end
    end
`else
    assign w_grant_data = w_grant_evt && data_req;
    assign w_grant_inst = w_grant_evt && inst_req && !data_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_grant_any) w_state_next = c_st_req;
            c_st_req:  if (mem_addr_ok) w_state_next = c_st_wait;
            c_st_wait: begin
                if (mem_data_ok) begin
                    w_state_next = w_grant_any ? c_st_req : c_st_idle;
                end
            end
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Request fields are captured once per grant and held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_data) begin
            r_owner <= 1'b1;
            r_wr    <= data_wr;
            r_wstrb <= data_wstrb;
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
        end else if (w_grant_inst) begin
            r_owner <= 1'b0;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_addr  <= inst_addr;
            r_wdata <= '0;
        end
    end

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_data_ok = w_resp && !r_owner;
    assign data_data_ok = w_resp && r_owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req   = (r_state == c_st_req);
    assign mem_wr    = r_wr;
    assign mem_wstrb = r_wstrb;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed and randomized bench for sram_port_arbiter against a
//            transaction-level reference model (honours ARB_ROUND_ROBIN_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req, data_req, data_wr;
    logic [AW-1:0] inst_addr, data_addr;
    logic [SW-1:0] data_wstrb;
    logic [DW-1:0] data_wdata;
    logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [DW-1:0] inst_rdata, data_rdata;
    logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_dok = 0;

    // Reference model: at most one transaction, either waiting for acceptance or for data
    logic          m_busy, m_acc, m_owner, m_last, m_wr;
    logic [SW-1:0] m_wstrb;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          mem_pending;

    logic          s_inst_addr_ok, s_data_addr_ok, s_inst_data_ok, s_data_data_ok;
    logic          s_mem_req, s_mem_wr, s_busy;
    logic [SW-1:0] s_mem_wstrb;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_wdata, s_inst_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, update the model, return just after the next rising edge
    task automatic step();
        logic       free, e_ido, e_ddo;
        logic [1:0] win;  // 0 none, 1 inst, 2 data
        @(negedge clk);
        s_inst_addr_ok = inst_addr_ok; s_data_addr_ok = data_addr_ok;
        s_inst_data_ok = inst_data_ok; s_data_data_ok = data_data_ok;
        s_mem_req = mem_req; s_mem_wr = mem_wr; s_busy = busy; s_mem_wstrb = mem_wstrb;
        s_mem_addr = mem_addr; s_mem_wdata = mem_wdata; s_inst_rdata = inst_rdata;
        if (data_data_ok === 1'b1) n_dok++;
        if (rst) begin
            chk("rst_inst_addr_ok", 64'(inst_addr_ok), 64'(0));
            chk("rst_data_addr_ok", 64'(data_addr_ok), 64'(0));
            chk("rst_inst_data_ok", 64'(inst_data_ok), 64'(0));
            chk("rst_data_data_ok", 64'(data_data_ok), 64'(0));
            m_busy = 0; m_acc = 0; m_last = 0; mem_pending = 0;
        end else begin
            free = !m_busy || (m_acc && mem_data_ok);
            win  = 2'd0;
            if (free) begin
                if (inst_req && data_req) win = (RR && m_last) ? 2'd1 : 2'd2;
                else if (data_req)        win = 2'd2;
                else if (inst_req)        win = 2'd1;
            end
            e_ido = m_busy && m_acc && mem_data_ok && !m_owner;
            e_ddo = m_busy && m_acc && mem_data_ok && m_owner;
            chk("inst_addr_ok", 64'(inst_addr_ok), 64'(win == 2'd1));
            chk("data_addr_ok", 64'(data_addr_ok), 64'(win == 2'd2));
            chk("inst_data_ok", 64'(inst_data_ok), 64'(e_ido));
            chk("data_data_ok", 64'(data_data_ok), 64'(e_ddo));
            if (e_ido) chk("inst_rdata", 64'(inst_rdata), 64'(mem_rdata));
            if (e_ddo) chk("data_rdata", 64'(data_rdata), 64'(mem_rdata));
            chk("mem_req", 64'(mem_req), 64'(m_busy && !m_acc));
            chk("busy", 64'(busy), 64'(m_busy));
            if (m_busy) begin
                chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                chk("mem_wr", 64'(mem_wr), 64'(m_wr));
                chk("mem_wstrb", 64'(mem_wstrb), 64'(m_wstrb));
                if (m_owner) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end
            if (mem_data_ok) mem_pending = 0;
            if (mem_req && mem_addr_ok) mem_pending = 1;
            if (m_busy && !m_acc && mem_addr_ok) m_acc = 1;
            if (free) begin
                m_busy = (win != 2'd0);
                m_acc  = 0;
                if (win == 2'd2) begin
                    m_owner = 1; m_wr = data_wr; m_wstrb = data_wstrb;
                    m_addr = data_addr; m_wdata = data_wdata; m_last = 1;
                end else if (win == 2'd1) begin
                    m_owner = 0; m_wr = 0; m_wstrb = '0;
                    m_addr = inst_addr; m_wdata = '0; m_last = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [2:0] tie_exp;

    initial begin
        rst = 1; inst_req = 0; data_req = 0; data_wr = 0; inst_addr = '0; data_addr = '0;
        data_wstrb = '0; data_wdata = '0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
        m_busy = 0; m_acc = 0; m_owner = 0; m_last = 0; m_wr = 0; m_wstrb = '0;
        m_addr = '0; m_wdata = '0; mem_pending = 0;
        @(posedge clk); #1;
        step(); step();
        rst = 0;
        step();
        chk("reset_mem_req", 64'(s_mem_req), 64'(0));
        chk("reset_mem_addr", 64'(s_mem_addr), 64'(0));
        chk("reset_mem_wdata", 64'(s_mem_wdata), 64'(0));
        chk("reset_mem_wr", 64'(s_mem_wr), 64'(0));
        chk("reset_mem_wstrb", 64'(s_mem_wstrb), 64'(0));
        chk("reset_busy", 64'(s_busy), 64'(0));

        // Single fetch, zero-wait memory
        inst_req = 1; inst_addr = 32'h1FC0_0000;
        step();
        chk("fetch_addr_ok_c0", 64'(s_inst_addr_ok), 64'(1));
        inst_req = 0; mem_addr_ok = 1;
        step();
        chk("fetch_mem_req_c1", 64'(s_mem_req), 64'(1));
        chk("fetch_mem_addr_c1", 64'(s_mem_addr), 64'(32'h1FC0_0000));
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C08_BFAF;
        step();
        chk("fetch_data_ok_c2", 64'(s_inst_data_ok), 64'(1));
        chk("fetch_rdata_c2", 64'(s_inst_rdata), 64'(32'h3C08_BFAF));
        mem_data_ok = 0;
        step();

        // Data write, memory stalls 5 cycles while fetch waits
        n_dok = 0;
        data_req = 1; data_wr = 1; data_wstrb = 4'h3; data_addr = 32'h0000_1004;
        data_wdata = 32'hDEAD_BEEF;
        step();
        chk("wr_addr_ok", 64'(s_data_addr_ok), 64'(1));
        data_req = 0; inst_req = 1; inst_addr = 32'h0040_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_mem_req", 64'(s_mem_req), 64'(1));
            chk("stall_mem_addr", 64'(s_mem_addr), 64'(32'h0000_1004));
            chk("stall_mem_wr", 64'(s_mem_wr), 64'(1));
            chk("stall_mem_wstrb", 64'(s_mem_wstrb), 64'(4'h3));
            chk("stall_mem_wdata", 64'(s_mem_wdata), 64'(32'hDEAD_BEEF));
            chk("stall_no_inst_grant", 64'(s_inst_addr_ok), 64'(0));
        end
        mem_addr_ok = 1;
        step();
        chk("accept_no_inst_grant", 64'(s_inst_addr_ok), 64'(0));
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
        step();
        chk("b2b_data_ok", 64'(s_data_data_ok), 64'(1));
        chk("b2b_inst_grant", 64'(s_inst_addr_ok), 64'(1));
        inst_req = 0; mem_data_ok = 0; mem_addr_ok = 1;
        step();
        chk("b2b_next_mem_req", 64'(s_mem_req), 64'(1));
        chk("b2b_fetch_wr", 64'(s_mem_wr), 64'(0));
        chk("b2b_fetch_wstrb", 64'(s_mem_wstrb), 64'(0));
        mem_addr_ok = 0; mem_data_ok = 1;
        step();
        mem_data_ok = 0;
        chk("wr_data_ok_pulses", 64'(n_dok), 64'(1));

        // Three back-to-back ties
        tie_exp = RR ? 3'b101 : 3'b111;
        inst_req = 1; inst_addr = 32'h0000_3000;
        data_req = 1; data_wr = 0; data_wstrb = '0; data_addr = 32'h0000_2000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tie_data_grant", 64'(s_data_addr_ok), 64'(tie_exp[i]));
            chk("tie_inst_grant", 64'(s_inst_addr_ok), 64'(!tie_exp[i]));
            mem_data_ok = 0;
            if (i == 2) begin inst_req = 0; data_req = 0; end
            mem_addr_ok = 1;
            step();
            mem_addr_ok = 0; mem_data_ok = 1;
        end
        step();
        mem_data_ok = 0;

        // Reset while waiting for data
        inst_req = 1; inst_addr = 32'h1FC0_0010;
        step();
        inst_req = 0; mem_addr_ok = 1;
        step();
        mem_addr_ok = 0; rst = 1;
        step();
        rst = 0; mem_data_ok = 1;
        step();
        chk("rstwait_busy", 64'(s_busy), 64'(0));
        chk("rstwait_mem_req", 64'(s_mem_req), 64'(0));
        chk("rstwait_inst_data_ok", 64'(s_inst_data_ok), 64'(0));
        chk("rstwait_data_data_ok", 64'(s_data_data_ok), 64'(0));
        mem_data_ok = 0;

        // Randomized traffic with a random-latency memory
        for (int c = 0; c < 3000; c++) begin
            if (s_inst_addr_ok || !inst_req) begin
                inst_req = ($urandom % 3 == 0); inst_addr = $urandom;
            end
            if (s_data_addr_ok || !data_req) begin
                data_req = ($urandom % 3 == 0); data_wr = $urandom % 2;
                data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = mem_req && ($urandom % 2 == 0);
            mem_data_ok = mem_pending ? ($urandom % 3 == 0) : (!mem_req && $urandom % 8 == 0);
            mem_rdata   = $urandom;
            rst         = ($urandom % 200 == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
